// File: rtl/ef_i2s_tx.sv
// I2S / left-justified master transmitter: generates sck/ws and shifts FIFO samples
// out MSB-first on sdo, one FIFO word per enabled channel slot.
module ef_i2s_tx #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [7:0]    i_sck_prescaler,
    input  logic [5:0]    i_sample_size,
    input  logic          i_left_justified,
    input  logic [1:0]    i_channels,
    input  logic          i_fifo_wr,
    input  logic [DW-1:0] i_fifo_wdata,
    input  logic          i_fifo_clr,
    input  logic [AW:0]   i_fifo_level_threshold,
    output logic          o_fifo_full,
    output logic          o_fifo_empty,
    output logic [AW:0]   o_fifo_level,
    output logic          o_fifo_level_below,
    output logic          o_underrun,
    input  logic          i_underrun_clr,
    output logic          o_sck,
    output logic          o_ws,
    output logic          o_sdo
);
    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0] r_mem [Depth];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [7:0]    r_presc;
    logic          r_sck;
    logic          r_ws;
    logic          r_sdo;
    logic          r_underrun;
    logic [4:0]    r_bit_ctr;
    logic [31:0]   r_sr;

    logic          w_tick;
    logic          w_fall;
    logic          w_slot;
    logic          w_left;
    logic          w_ch_en;
    logic          w_push;
    logic          w_pop;
    logic          w_starve;
    logic [5:0]    w_size;
    logic [5:0]    w_shamt;
    logic [31:0]   w_word;
    logic [31:0]   w_aligned;

    assign w_tick = i_en && (r_presc == 8'd0);
    assign w_fall = w_tick && r_sck;
    assign w_slot = w_fall && (r_bit_ctr == (i_left_justified ? 5'd0 : 5'd1));
    // LJ uses the post-toggle ws (left when 1), I2S the current ws (left when 0): both are ~r_ws.
    assign w_left = ~r_ws;
    assign w_ch_en = w_left ? i_channels[1] : i_channels[0];

    assign w_push   = i_fifo_wr && !o_fifo_full;
    assign w_pop    = w_slot && w_ch_en && !o_fifo_empty;
    assign w_starve = w_slot && w_ch_en && o_fifo_empty;

    assign w_size    = (i_sample_size == 6'd0 || i_sample_size > 6'd32) ? 6'd32 : i_sample_size;
    assign w_shamt   = 6'd32 - w_size;
    assign w_word    = 32'(r_mem[r_rd_ptr]);
    assign w_aligned = w_word << w_shamt;

    assign o_fifo_level       = r_level;
    assign o_fifo_empty       = (r_level == '0);
    assign o_fifo_full        = (r_level == Depth[AW:0]);
    assign o_fifo_level_below = (r_level < i_fifo_level_threshold);
    assign o_underrun         = r_underrun;
    assign o_sck              = r_sck;
    assign o_ws               = r_ws;
    assign o_sdo              = r_sdo;

    always_ff @(posedge i_clk) begin
        if (w_push && !i_fifo_clr) begin
            r_mem[r_wr_ptr] <= i_fifo_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_fifo_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_presc   <= '0;
            r_sck     <= 1'b0;
            r_ws      <= 1'b1;
            r_sdo     <= 1'b0;
            r_bit_ctr <= '0;
            r_sr      <= '0;
        end else begin
            r_presc <= (r_presc == 8'd0) ? i_sck_prescaler : r_presc - 8'd1;
            if (w_tick) begin
                r_sck <= ~r_sck;
            end
            if (w_fall) begin
                r_bit_ctr <= r_bit_ctr + 5'd1;
                if (r_bit_ctr == 5'd0) begin
                    r_ws <= ~r_ws;
                end
                if (w_slot) begin
                    if (w_pop) begin
                        r_sr  <= w_aligned;
                        r_sdo <= w_aligned[31];
                    end else begin
                        r_sr  <= '0;
                        r_sdo <= 1'b0;
                    end
                end else begin
                    r_sr  <= {r_sr[30:0], 1'b0};
                    r_sdo <= r_sr[30];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_underrun <= 1'b0;
        end else if (w_starve) begin
            r_underrun <= 1'b1;
        end else if (i_underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

endmodule
